imem_fetch: RTL and testbench

IMEM_FETCH -- requirements
Module: imem_fetch

---
 rtl/imem_fetch.sv | 130 +++++++++++++
 tb/tb_imem_fetch.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch.sv
// Instruction memory with a fixed-latency read pipeline and an in-order response queue.
// Request/response handshakes; flush discards everything in flight.
module imem_fetch #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 1,
    parameter int QDEPTH  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_inst,
    output logic [4:0]  rsp_rd,
    output logic [4:0]  rsp_rs1,
    output logic [4:0]  rsp_rs2,
    output logic        rsp_err,
    input  logic        wr_en,
    input  logic [31:0] wr_addr,
    input  logic [31:0] wr_data,
    output logic        busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int QW = $clog2(QDEPTH);
    localparam logic [QW:0] QMAX = QDEPTH[QW:0];

    logic [31:0] mem [DEPTH];
    logic [31:0] q_inst [QDEPTH];
    logic [QDEPTH-1:0] q_err;
    logic [QW:0] cnt, wp, rp;
    logic acc, deq;
    logic rd_err;
    logic [31:0] rd_inst;
    logic enq_v, enq_err;
    logic [31:0] enq_inst;
    logic unused_wr_lsb;

    assign unused_wr_lsb = ^wr_addr[1:0];

    assign req_ready = (cnt < QMAX) && !flush;
    assign acc       = req_valid && req_ready;
    assign rsp_valid = (wp != rp);
    assign deq       = rsp_valid && rsp_ready;
    assign busy      = (cnt != '0);

    assign rd_err  = (|req_addr[1:0]) || (|req_addr[31:AW+2]);
    assign rd_inst = rd_err ? 32'h0 : mem[req_addr[AW+1:2]];

    always_ff @(posedge clk) begin
        if (wr_en && (wr_addr[31:AW+2] == '0))
            mem[wr_addr[AW+1:2]] <= wr_data;
    end

    if (LATENCY == 1) begin : g_direct
        assign enq_v    = acc;
        assign enq_inst = rd_inst;
        assign enq_err  = rd_err;
    end else begin : g_pipe
        localparam int PL = LATENCY - 1;
        logic [PL-1:0] pv;
        logic [PL-1:0] pe;
        logic [31:0]   p_inst [PL];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                pv <= '0;
            end else if (flush) begin
                pv <= '0;
            end else begin
                pv[0] <= acc;
                for (int i = 1; i < PL; i++)
                    pv[i] <= pv[i-1];
            end
        end

        always_ff @(posedge clk) begin
            p_inst[0] <= rd_inst;
            pe[0]     <= rd_err;
            for (int i = 1; i < PL; i++) begin
                p_inst[i] <= p_inst[i-1];
                pe[i]     <= pe[i-1];
            end
        end

        assign enq_v    = pv[PL-1];
        assign enq_inst = p_inst[PL-1];
        assign enq_err  = pe[PL-1];
    end

    // cnt bounds the queue occupancy, so the queue cannot overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else if (flush) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (enq_v)
                wp <= wp + 1'b1;
            if (deq)
                rp <= rp + 1'b1;
            unique case ({acc, deq})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (enq_v) begin
            q_inst[wp[QW-1:0]] <= enq_inst;
            q_err[wp[QW-1:0]]  <= enq_err;
        end
    end

    assign rsp_inst = rsp_valid ? q_inst[rp[QW-1:0]] : 32'h0;
    assign rsp_err  = rsp_valid && q_err[rp[QW-1:0]];
    assign rsp_rd   = rsp_inst[11:7];
    assign rsp_rs1  = rsp_inst[19:15];
    assign rsp_rs2  = rsp_inst[24:20];

endmodule

// File: tb/tb_imem_fetch.sv
// Directed bench for imem_fetch: LATENCY=1 and LATENCY=3 instances
// share stimulus; each scenario checks against hand-computed values.
module tb_imem_fetch;

    logic        clk, rst_n, flush;
    logic        req_valid, rsp_ready, wr_en;
    logic [31:0] req_addr, wr_addr, wr_data;

    logic        rdy1, vld1, err1, busy1;
    logic [31:0] inst1;
    logic [4:0]  rd1, rs11, rs21;
    logic        rdy3, vld3, err3, busy3;
    logic [31:0] inst3;
    logic [4:0]  rd3, rs13, rs23;

    int n_tests = 0;
    int n_fail  = 0;

    imem_fetch #(.DEPTH(1024), .LATENCY(1), .QDEPTH(4)) u_l1 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req_valid(req_valid), .req_ready(rdy1), .req_addr(req_addr),
        .rsp_valid(vld1), .rsp_ready(rsp_ready), .rsp_inst(inst1),
        .rsp_rd(rd1), .rsp_rs1(rs11), .rsp_rs2(rs21), .rsp_err(err1),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy1)
    );

    imem_fetch #(.DEPTH(1024), .LATENCY(3), .QDEPTH(4)) u_l3 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req_valid(req_valid), .req_ready(rdy3), .req_addr(req_addr),
        .rsp_valid(vld3), .rsp_ready(rsp_ready), .rsp_inst(inst3),
        .rsp_rd(rd3), .rsp_rs1(rs13), .rsp_rs2(rs23), .rsp_err(err3),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic load_mem;
        wr(32'h0, 32'h0050_0093);
        wr(32'h5, 32'h00A0_0113);
        wr(32'h8, 32'h0020_81B3);
        wr(32'hC, 32'hDEAD_BEEF);
        wr(32'h1000, 32'hFFFF_FFFF);
    endtask

    logic [31:0] words [4];
    int n_acc;

    initial begin
        words[0] = 32'h0050_0093;
        words[1] = 32'h00A0_0113;
        words[2] = 32'h0020_81B3;
        words[3] = 32'hDEAD_BEEF;
        rst_n = 1'b0; flush = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
        wr_en = 1'b0; req_addr = '0; wr_addr = '0; wr_data = '0;
        #3;
        chk("rst_vld", 32'(vld1), 0);
        chk("rst_busy", 32'(busy1), 0);
        chk("rst_inst", inst1, 0);
        chk("rst_err", 32'(err1), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("rst_rdy", 32'(rdy1), 1);
        load_mem();

        // basic fetch, LATENCY=1
        req_valid = 1'b1; req_addr = 32'h0;
        tick();
        req_valid = 1'b0;
        chk("f0_vld", 32'(vld1), 1);
        chk("f0_inst", inst1, 32'h0050_0093);
        chk("f0_rd", 32'(rd1), 1);
        chk("f0_rs1", 32'(rs11), 0);
        chk("f0_rs2", 32'(rs21), 5);
        chk("f0_err", 32'(err1), 0);
        rsp_ready = 1'b1;
        tick();
        chk("f0_done", 32'(vld1), 0);
        repeat (4) tick();

        // read-old on same-cycle write
        req_valid = 1'b1; req_addr = 32'hC;
        wr_en = 1'b1; wr_addr = 32'hC; wr_data = 32'h1234_5678;
        tick();
        req_valid = 1'b0; wr_en = 1'b0;
        chk("rdold", inst1, 32'hDEAD_BEEF);
        tick();
        req_valid = 1'b1; req_addr = 32'hC;
        tick();
        req_valid = 1'b0;
        chk("rdnew", inst1, 32'h1234_5678);
        wr(32'hC, 32'hDEAD_BEEF);
        repeat (4) tick();

        // misaligned and out-of-range
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_addr = 32'h2;
        tick();
        req_addr = 32'h1000;
        tick();
        req_valid = 1'b0;
        chk("e0_err", 32'(err1), 1);
        chk("e0_inst", inst1, 0);
        rsp_ready = 1'b1;
        tick();
        chk("e1_vld", 32'(vld1), 1);
        chk("e1_err", 32'(err1), 1);
        chk("e1_inst", inst1, 0);
        tick();
        chk("e_done", 32'(vld1), 0);
        repeat (4) tick();

        // queue fill under backpressure
        rsp_ready = 1'b0;
        n_acc = 0;
        req_valid = 1'b1; req_addr = 32'h0;
        for (int c = 0; c < 7; c++) begin
            if (rdy1) n_acc++;
            tick();
            req_addr = 32'(4 * n_acc);
        end
        chk("q_acc", 32'(n_acc), 4);
        chk("q_rdy", 32'(rdy1), 0);
        chk("q_busy", 32'(busy1), 1);
        chk("q_hold", inst1, words[0]);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("q_vld%0d", i), 32'(vld1), 1);
            chk($sformatf("q_inst%0d", i), inst1, words[i]);
            tick();
        end
        chk("q_empty", 32'(vld1), 0);
        chk("q_idle", 32'(busy1), 0);
        req_valid = 1'b1; req_addr = 32'h4;
        chk("q_resume", 32'(rdy1), 1);
        tick();
        req_valid = 1'b0;
        chk("q_wrap", inst1, words[1]);
        repeat (4) tick();

        // flush with two outstanding
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_addr = 32'h0;
        tick();
        req_addr = 32'h4;
        tick();
        chk("fl_busy0", 32'(busy1), 1);
        flush = 1'b1; rsp_ready = 1'b1; req_addr = 32'h8;
        #1;
        chk("fl_rdy", 32'(rdy1), 0);
        tick();
        flush = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
        chk("fl_vld", 32'(vld1), 0);
        chk("fl_busy", 32'(busy1), 0);
        req_valid = 1'b1; req_addr = 32'h8;
        tick();
        req_valid = 1'b0;
        chk("fl_inst", inst1, words[2]);
        chk("fl_rd", 32'(rd1), 3);
        chk("fl_rs1", 32'(rs11), 1);
        chk("fl_rs2", 32'(rs21), 2);
        rsp_ready = 1'b1;
        tick();
        chk("fl_done", 32'(vld1), 0);
        repeat (4) tick();

        // asynchronous reset mid-stream
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_addr = 32'h0;
        tick();
        req_addr = 32'h4;
        tick();
        req_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_vld", 32'(vld1), 0);
        chk("ar_inst", inst1, 0);
        chk("ar_busy", 32'(busy1), 0);
        chk("ar_busy3", 32'(busy3), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("ar_rdy", 32'(rdy1), 1);
        chk("ar_stale", 32'(vld1), 0);
        load_mem();

        // LATENCY=3 back-to-back
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_addr = 32'h0;
        tick();
        req_addr = 32'h4;
        tick();
        chk("l3_early", 32'(vld3), 0);
        req_addr = 32'h8;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("l3_vld%0d", i), 32'(vld3), 1);
            chk($sformatf("l3_inst%0d", i), inst3, words[i]);
            tick();
        end
        chk("l3_done", 32'(vld3), 0);
        chk("l3_busy", 32'(busy3), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
